alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller that drives the 8-bit datapath ALU. It accepts 9-bit instructions over a valid/ready handshake and reads operands from an internal 8×8-bit register file. It presents opcode and operands to the ALU, captures the ALU's result or zero output, and writes the result back to a register or to the condition bit (CB). It sits between the instruction fetch stage and the ALU.

## Interface
Parameters:
- NREGS, 8, register count; fixed at 8 by the 3-bit register fields.
- WIDTH, 8, datapath width; must match the ALU.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_valid_i  in  1  instruction present on instr_i.
- instr_ready_o  out  1  controller can accept an instruction.
- instr_i  in  9  instruction: [8:6] op, [5:3] rs/rd, [2:0] rt.
- alu_opcode_o  out  3  opcode driven to the ALU.
- alu_rs_o  out  8  first operand to the ALU.
- alu_rt_o  out  8  second operand to the ALU.
- alu_result_i  in  8  ALU result.
- alu_zero_i  in  1  ALU compare output (slt/seq only).
- cb_o  out  1  condition bit.
- done_o  out  1  one-cycle pulse when an instruction retires.
- dbg_addr_i  in  3  debug register select.
- dbg_data_o  out  8  register contents; combinational read.

## Operation
- Op encoding: 000 and, 001 add, 010 sll, 011 srl, 100 sub, 101 slt, 110 abs, 111 seq.
- Compare ops (slt, seq) write CB from alu_zero_i. No register is written for these ops.
- All other ops write alu_result_i into R[rd], where rd equals rs (instr_i[5:3]).
- For the srl and abs ops, the rt field is still read and driven to the ALU, which ignores it.
- The FSM has four states:
  - IDLE: instr_ready_o = 1. A handshake (valid & ready) latches instr_i and moves to READ.
  - READ: latches R[rs] and R[rt] into the operand registers. Moves to EXEC.
  - EXEC: drives alu_opcode_o and the latched operands. Samples alu_result_i and alu_zero_i into capture registers. Moves to WB.
  - WB: commits the captured value to R[rd] or to CB. Asserts done_o. Moves to IDLE.
- The ALU is combinational and holds stale outputs for fields it does not update. The controller therefore ignores alu_result_i for compare ops and ignores alu_zero_i for all other ops.
- ALU ports are driven only from the operand registers. Their values outside EXEC are don't-care but must be stable (no X after reset).
- Arithmetic wraps modulo 2^8. The controller performs no width extension.

## Timing
- Reset values:
  - State: IDLE.
  - All registers R0–R7: 0x00.
  - cb_o: 0.
  - done_o: 0.
  - alu_opcode_o, alu_rs_o, alu_rt_o: 0.
  - instr_ready_o: 1 (decoded from IDLE).
- Latency: for a handshake in cycle N, done_o is high in cycle N+3 and the written value is visible on dbg_data_o in cycle N+4. Throughput is one instruction per 4 cycles.
- instr_ready_o is low in READ, EXEC and WB. instr_valid_i is ignored in those states, and instr_i may change freely.
- Back-to-back: a handshake may occur in the IDLE cycle immediately after WB. That instruction's READ sees the value just written, so no hazard exists.
- rs == rt: both operands equal R[rs]. For example, sub r3,r3 gives 0x00.
- dbg_data_o during the WB cycle shows the old value; the new value appears the next cycle.
- Reset asserted mid-instruction: the instruction is aborted immediately, with no writeback, no CB update and no done_o. All state returns to reset values asynchronously.
- CB holds its value until the next compare op retires or reset is applied.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams: OP_AND … OP_SEQ.
  - Instruction field positions.
  - The FSM state encoding: ST_IDLE, ST_READ, ST_EXEC, ST_WB.
- The register file is a natural sub-module, alu_regfile:
  - 8×8 storage with asynchronous reset to 0.
  - Two combinational read ports (operands) plus one combinational debug read port.
  - One synchronous write port.
- The FSM, operand and capture registers, and CB live in alu_issue_ctrl.
- The ALU itself is instantiated at the level above, not inside this block.

## Test plan
Each scenario connects the real ALU in the bench.
- Reset, then preload R1=0x05 and R2=0x03 via add-from-zero sequences. Issue add r1,r2 → done_o in cycle N+3; R1=0x08; cb_o unchanged at 0.
- R4=0xFF, R5=0x02, issue add r4,r5 → R4=0x01 (wrap). Then issue sub r5,r4 → R5=0x01.
- R6=0x03, R7=0x09:
  - slt r6,r7 → cb_o=1, R6 unchanged.
  - seq r6,r6 → cb_o=1.
  - seq r6,r7 → cb_o=0, and no register changes.
- R3=0xFB, issue abs r3 → R3=0x05. Then srl r3 → R3=0x02.
- Hold instr_valid_i high with a new instruction during READ, EXEC and WB → only one instruction is accepted. The second is accepted in the next IDLE cycle, and its done_o arrives exactly 4 cycles after the first.
- Assert rst_i during EXEC of add r1,r2 → no done_o; all registers read 0x00, cb_o=0 and instr_ready_o=1 after reset is released.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue controller: opcode encodings,
// instruction field positions, FSM state encoding and a compare-op helper.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_ABS = 3'b110;
    localparam logic [2:0] OP_SEQ = 3'b111;

    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 3;
    localparam int RT_MSB  = 2;
    localparam int RT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_t;

    // Compare ops retire into CB instead of the register file.
    function automatic logic is_compare(input logic [2:0] op);
        return (op == OP_SLT) || (op == OP_SEQ);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_regfile
// 8x8 register file: two combinational operand read ports, one combinational
// debug read port and one synchronous write port. All entries reset to 0.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   we_i/waddr_i/wdata_i  write port
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o  operand read ports
//   dbg_addr_i/dbg_data_o  debug read port
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [2:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [2:0]       raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [2:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [2:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem[raddr_a_i];
    assign rdata_b_o  = mem[raddr_b_i];
    assign dbg_data_o = mem[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Multi-cycle issue controller for the 8-bit datapath ALU. Accepts one
// instruction per four cycles, reads operands from the internal register
// file, presents them to the external ALU, and writes the result back to a
// register or (for compare ops) to the condition bit.
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   instr_valid_i/instr_ready_o/instr_i  instruction handshake
//   alu_opcode_o/alu_rs_o/alu_rt_o   ALU inputs (registered)
//   alu_result_i/alu_zero_i          ALU outputs
//   cb_o                             condition bit
//   done_o                           one-cycle retire pulse
//   dbg_addr_i/dbg_data_o            combinational register peek
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a new instruction; handshake latches instr_i
// READ    | latch R[rs] and R[rt] into the operand registers
// EXEC    | ALU sees opcode/operands; capture result and zero flag
// WB      | commit capture to R[rd] or CB; done_o is high
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [2:0]         alu_opcode_o,
    output logic [WIDTH-1:0]   alu_rs_o,
    output logic [WIDTH-1:0]   alu_rt_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    input  logic               alu_zero_i,
    output logic               cb_o,
    output logic               done_o,
    input  logic [2:0]         dbg_addr_i,
    output logic [WIDTH-1:0]   dbg_data_o
);

    state_t             state;
    logic [INSTR_W-1:0] instr_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   cap_result_q;
    logic               cap_zero_q;

    logic [2:0]         op_field;
    logic [2:0]         rs_field;
    logic [2:0]         rt_field;
    logic [WIDTH-1:0]   rf_rdata_a;
    logic [WIDTH-1:0]   rf_rdata_b;
    logic               rf_we;

    assign op_field = instr_q[OP_MSB:OP_LSB];
    assign rs_field = instr_q[RS_MSB:RS_LSB];
    assign rt_field = instr_q[RT_MSB:RT_LSB];

    // The write lands on the edge that leaves WB, so dbg_data_o shows the
    // old value during WB and the new one in the following IDLE cycle.
    assign rf_we = (state == ST_WB) && !is_compare(op_field);

    alu_regfile #(
        .NREGS (NREGS),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (rf_we),
        .waddr_i    (rs_field),
        .wdata_i    (cap_result_q),
        .raddr_a_i  (rs_field),
        .rdata_a_o  (rf_rdata_a),
        .raddr_b_i  (rt_field),
        .rdata_b_o  (rf_rdata_b),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o)
    );

    // ALU inputs come straight from registers so they never glitch or go X.
    assign alu_opcode_o = op_field;
    assign alu_rs_o     = op_a_q;
    assign alu_rt_o     = op_b_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            instr_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cap_result_q  <= '0;
            cap_zero_q    <= 1'b0;
            cb_o          <= 1'b0;
            done_o        <= 1'b0;
            instr_ready_o <= 1'b1;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid_i && instr_ready_o) begin
                        instr_q       <= instr_i;
                        instr_ready_o <= 1'b0;
                        state         <= ST_READ;
                    end
                end
                ST_READ: begin
                    op_a_q <= rf_rdata_a;
                    op_b_q <= rf_rdata_b;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Both ALU outputs are captured; only the one relevant to
                    // the op is used in WB, the other may be stale.
                    cap_result_q <= alu_result_i;
                    cap_zero_q   <= alu_zero_i;
                    done_o       <= 1'b1;
                    state        <= ST_WB;
                end
                ST_WB: begin
                    if (is_compare(op_field)) begin
                        cb_o <= cap_zero_q;
                    end
                    instr_ready_o <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    instr_ready_o <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic [8:0] instr_i;
    logic [2:0] alu_opcode_o;
    logic [7:0] alu_rs_o;
    logic [7:0] alu_rt_o;
    logic [7:0] alu_result_i;
    logic       alu_zero_i;
    logic       cb_o;
    logic       done_o;
    logic [2:0] dbg_addr_i;
    logic [7:0] dbg_data_o;

    int checks   = 0;
    int failures = 0;

    // reference architectural state
    logic [7:0] ref_regs [8];
    logic       ref_cb;

    // bench ALU controls
    logic       ovr_en;
    logic [7:0] ovr_val;
    logic [7:0] junk_res;
    logic       junk_z;

    alu_issue_ctrl #(.NREGS(8), .WIDTH(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .alu_opcode_o  (alu_opcode_o),
        .alu_rs_o      (alu_rs_o),
        .alu_rt_o      (alu_rt_o),
        .alu_result_i  (alu_result_i),
        .alu_zero_i    (alu_zero_i),
        .cb_o          (cb_o),
        .done_o        (done_o),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_data_o    (dbg_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ALU behaviour: returns {zero, result}. srl shifts by one, abs ignores rt.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       z;
        r = 8'h00;
        z = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a + b;
            3'd2: r = a << b[2:0];
            3'd3: r = a >> 1;
            3'd4: r = a - b;
            3'd5: z = ($signed(a) < $signed(b));
            3'd6: r = a[7] ? (8'h00 - a) : a;
            default: z = (a == b);
        endcase
        return {z, r};
    endfunction

    function automatic bit is_cmp(input logic [2:0] op);
        return (op == 3'd5) || (op == 3'd7);
    endfunction

    // Real-ALU stand-in: fields the op does not update carry junk, so the
    // controller must ignore them.
    always_comb begin
        logic [8:0] f;
        f = alu_f(alu_opcode_o, alu_rs_o, alu_rt_o);
        alu_result_i = ovr_en ? ovr_val : (is_cmp(alu_opcode_o) ? junk_res : f[7:0]);
        alu_zero_i   = is_cmp(alu_opcode_o) ? f[8] : junk_z;
    end

    task automatic reset_model();
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        ref_cb = 1'b0;
    endtask

    // Issues one instruction with full timing checks and updates the model.
    task automatic issue(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input bit ovr, input logic [7:0] ovr_v);
        logic [7:0] a, b;
        logic [8:0] f;
        int n;
        n = 0;
        while (!instr_ready_o && n < 16) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (instr_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready_timeout got=%b want=1", instr_ready_o);
        end
        a = ref_regs[rs];
        b = ref_regs[rt];
        f = alu_f(op, a, b);
        ovr_en   = ovr;
        ovr_val  = ovr_v;
        junk_res = 8'($urandom);
        junk_z   = 1'($urandom);
        instr_i  = {op, rs, rt};
        instr_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        // READ: new requests must be ignored
        instr_valid_i = 1'($urandom_range(0, 1));
        instr_i       = 9'($urandom);
        checks++;
        if (instr_ready_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL read_state got ready=%b done=%b want ready=0 done=0", instr_ready_o, done_o);
        end
        @(negedge clk_i);
        // EXEC
        checks++;
        if (done_o !== 1'b0 || alu_opcode_o !== op || alu_rs_o !== a || alu_rt_o !== b) begin
            failures++;
            $display("FAIL exec_operands got done=%b op=%0d rs=%h rt=%h want done=0 op=%0d rs=%h rt=%h",
                     done_o, alu_opcode_o, alu_rs_o, alu_rt_o, op, a, b);
        end
        @(negedge clk_i);
        // WB: done high, register still old
        dbg_addr_i = rs;
        #1;
        checks++;
        if (done_o !== 1'b1 || dbg_data_o !== a) begin
            failures++;
            $display("FAIL wb_cycle got done=%b dbg=%h want done=1 dbg=%h", done_o, dbg_data_o, a);
        end
        instr_valid_i = 1'b0;
        if (is_cmp(op)) ref_cb = f[8];
        else ref_regs[rs] = ovr ? ovr_v : f[7:0];
        @(negedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b0 || instr_ready_o !== 1'b1 || dbg_data_o !== ref_regs[rs] || cb_o !== ref_cb) begin
            failures++;
            $display("FAIL retire got done=%b ready=%b dbg=%h cb=%b want done=0 ready=1 dbg=%h cb=%b",
                     done_o, instr_ready_o, dbg_data_o, cb_o, ref_regs[rs], ref_cb);
        end
        ovr_en = 1'b0;
    endtask

    task automatic preload(input logic [2:0] rd, input logic [7:0] v);
        issue(3'd1, rd, 3'd0, 1'b1, v);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #12;
        @(negedge clk_i);
        checks++;
        if (instr_ready_o !== 1'b1 || done_o !== 1'b0 || cb_o !== 1'b0 ||
            alu_opcode_o !== 3'd0 || alu_rs_o !== 8'h00 || alu_rt_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b done=%b cb=%b op=%0d rs=%h rt=%h want 1 0 0 0 00 00",
                     instr_ready_o, done_o, cb_o, alu_opcode_o, alu_rs_o, alu_rt_o);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            checks++;
            if (dbg_data_o !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg r%0d got=%h want=00", i, dbg_data_o);
            end
        end
        rst_i = 1'b0;
        reset_model();
        @(negedge clk_i);
    endtask

    task automatic test_add();
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(3'd1, 3'd1, 3'd2, 1'b0, 8'h00);
        dbg_addr_i = 3'd1;
        #1;
        checks++;
        if (dbg_data_o !== 8'h08 || cb_o !== 1'b0) begin
            failures++;
            $display("FAIL add_r1_r2 got r1=%h cb=%b want r1=08 cb=0", dbg_data_o, cb_o);
        end
    endtask

    task automatic test_wrap();
        preload(3'd4, 8'hFF);
        preload(3'd5, 8'h02);
        issue(3'd1, 3'd4, 3'd5, 1'b0, 8'h00);
        dbg_addr_i = 3'd4;
        #1;
        checks++;
        if (dbg_data_o !== 8'h01) begin
            failures++;
            $display("FAIL add_wrap got r4=%h want=01", dbg_data_o);
        end
        issue(3'd4, 3'd5, 3'd4, 1'b0, 8'h00);
        dbg_addr_i = 3'd5;
        #1;
        checks++;
        if (dbg_data_o !== 8'h01) begin
            failures++;
            $display("FAIL sub_r5_r4 got r5=%h want=01", dbg_data_o);
        end
        preload(3'd3, 8'h5A);
        issue(3'd4, 3'd3, 3'd3, 1'b0, 8'h00);
        dbg_addr_i = 3'd3;
        #1;
        checks++;
        if (dbg_data_o !== 8'h00) begin
            failures++;
            $display("FAIL sub_same_reg got r3=%h want=00", dbg_data_o);
        end
    endtask

    task automatic test_compare();
        logic [7:0] snap [8];
        preload(3'd6, 8'h03);
        preload(3'd7, 8'h09);
        for (int i = 0; i < 8; i++) snap[i] = ref_regs[i];
        issue(3'd5, 3'd6, 3'd7, 1'b0, 8'h00);
        checks++;
        if (cb_o !== 1'b1) begin
            failures++;
            $display("FAIL slt_r6_r7 got cb=%b want=1", cb_o);
        end
        issue(3'd7, 3'd6, 3'd6, 1'b0, 8'h00);
        checks++;
        if (cb_o !== 1'b1) begin
            failures++;
            $display("FAIL seq_r6_r6 got cb=%b want=1", cb_o);
        end
        issue(3'd7, 3'd6, 3'd7, 1'b0, 8'h00);
        checks++;
        if (cb_o !== 1'b0) begin
            failures++;
            $display("FAIL seq_r6_r7 got cb=%b want=0", cb_o);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            checks++;
            if (dbg_data_o !== snap[i]) begin
                failures++;
                $display("FAIL compare_no_write r%0d got=%h want=%h", i, dbg_data_o, snap[i]);
            end
        end
        // CB must hold across a non-compare op
        issue(3'd7, 3'd6, 3'd6, 1'b0, 8'h00);
        issue(3'd0, 3'd7, 3'd6, 1'b0, 8'h00);
        checks++;
        if (cb_o !== 1'b1) begin
            failures++;
            $display("FAIL cb_hold got cb=%b want=1", cb_o);
        end
    endtask

    task automatic test_abs_srl();
        preload(3'd3, 8'hFB);
        issue(3'd6, 3'd3, 3'd1, 1'b0, 8'h00);
        dbg_addr_i = 3'd3;
        #1;
        checks++;
        if (dbg_data_o !== 8'h05) begin
            failures++;
            $display("FAIL abs_r3 got r3=%h want=05", dbg_data_o);
        end
        issue(3'd3, 3'd3, 3'd2, 1'b0, 8'h00);
        #1;
        checks++;
        if (dbg_data_o !== 8'h02) begin
            failures++;
            $display("FAIL srl_r3 got r3=%h want=02", dbg_data_o);
        end
    endtask

    task automatic test_back_to_back();
        int hs_cyc [$];
        int done_cyc [$];
        logic [7:0] r1_exp, r2_exp;
        preload(3'd1, 8'h10);
        preload(3'd2, 8'h22);
        r1_exp = 8'h32;
        r2_exp = 8'h54;
        @(negedge clk_i);
        instr_i = {3'd1, 3'd1, 3'd2};
        instr_valid_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bit hs;
            hs = instr_valid_i && instr_ready_o;
            if (hs) hs_cyc.push_back(i);
            @(posedge clk_i);
            @(negedge clk_i);
            if (hs_cyc.size() == 1) instr_i = {3'd1, 3'd2, 3'd1};
            if (hs_cyc.size() >= 2) instr_valid_i = 1'b0;
            if (done_o === 1'b1) done_cyc.push_back(i + 1);
        end
        instr_valid_i = 1'b0;
        checks++;
        if (hs_cyc.size() != 2 || done_cyc.size() != 2) begin
            failures++;
            $display("FAIL b2b_counts got hs=%0d done=%0d want hs=2 done=2", hs_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (hs_cyc[1] - hs_cyc[0] != 4 || done_cyc[0] - hs_cyc[0] != 3 || done_cyc[1] - done_cyc[0] != 4) begin
                failures++;
                $display("FAIL b2b_timing got hs=%0d,%0d done=%0d,%0d want hs gap 4, latency 3, done gap 4",
                         hs_cyc[0], hs_cyc[1], done_cyc[0], done_cyc[1]);
            end
        end
        ref_regs[1] = r1_exp;
        ref_regs[2] = r2_exp;
        dbg_addr_i = 3'd1;
        #1;
        checks++;
        if (dbg_data_o !== r1_exp) begin
            failures++;
            $display("FAIL b2b_r1 got=%h want=%h", dbg_data_o, r1_exp);
        end
        dbg_addr_i = 3'd2;
        #1;
        checks++;
        if (dbg_data_o !== r2_exp) begin
            failures++;
            $display("FAIL b2b_r2 got=%h want=%h", dbg_data_o, r2_exp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom));
        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            checks++;
            if (dbg_data_o !== ref_regs[i]) begin
                failures++;
                $display("FAIL random_final r%0d got=%h want=%h", i, dbg_data_o, ref_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(3'd7, 3'd0, 3'd0, 1'b0, 8'h00);
        @(negedge clk_i);
        instr_i = {3'd1, 3'd1, 3'd2};
        instr_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        // now in EXEC
        rst_i = 1'b1;
        #1;
        checks++;
        if (instr_ready_o !== 1'b1 || done_o !== 1'b0 || cb_o !== 1'b0 || alu_rs_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_async got ready=%b done=%b cb=%b rs=%h want 1 0 0 00",
                     instr_ready_o, done_o, cb_o, alu_rs_o);
        end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) seen_done++;
        end
        rst_i = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL reset_no_done got pulses=%0d want=0", seen_done);
        end
        checks++;
        if (cb_o !== 1'b0 || instr_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got cb=%b ready=%b want cb=0 ready=1", cb_o, instr_ready_o);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            checks++;
            if (dbg_data_o !== 8'h00) begin
                failures++;
                $display("FAIL reset_mid_reg r%0d got=%h want=00", i, dbg_data_o);
            end
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        instr_valid_i = 1'b0;
        instr_i       = 9'h000;
        dbg_addr_i    = 3'd0;
        ovr_en        = 1'b0;
        ovr_val       = 8'h00;
        junk_res      = 8'h00;
        junk_z        = 1'b0;
        reset_model();
        test_reset();
        test_add();
        test_wrap();
        test_compare();
        test_abs_srl();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
